cut_spongent_adapter: RTL
=========================

# cut_spongent_adapter

Bridges the autotest controller's parallel CUT interface to the byte-streaming Spongent hash core. On release of `rst_cut` it streams the `DATA_WIDTH`-bit test message into the core one byte at a time, least-significant byte first. It then collects the N-bit digest byte by byte and presents it on `output_from_cut` with a level `end_cut` flag. It also measures how many cycles the hash core takes, for the measurement path.

## Interface
Parameters are taken from the `configuration` package.
- `DATA_WIDTH`, default 32: message width; multiple of 8, ≥ 8.
- `N`, default 88: digest width; multiple of 8, ≥ 8.

Ports:
- `clk` in 1: single system clock.
- `rst` in 1: synchronous, active-high reset.
- `rst_cut` in 1: synchronous, active-high CUT reset from the autotest controller; holds the block idle.
- `input_to_cut` in `DATA_WIDTH`: message; byte i = bits [8i+7:8i].
- `output_from_cut` out N: digest register; byte k = bits [8k+7:8k].
- `end_cut` out 1: level signal, digest complete.
- `hash_rst` out 1: reset to the hash core.
- `hash_data` out 8: message byte to the core.
- `hash_valid` out 1: `hash_data` is valid.
- `hash_last` out 1: final message byte; qualified by `hash_valid`.
- `hash_ready` in 1: core accepts a byte this cycle.
- `hash_out` in 8: digest byte from the core.
- `hash_out_valid` in 1: one-cycle strobe per digest byte; no backpressure.
- `cycle_count` out 32: cycles spent in ABSORB plus SQUEEZE.
- `proto_err` out 1: sticky protocol-error flag.

## Operation
States: IDLE, ABSORB, SQUEEZE, DONE. All state is updated on the rising edge of `clk`.

Priority for every register: `rst` first, then `rst_cut`, then normal operation.

- **`rst` or `rst_cut` high:**
  - Next state is IDLE.
  - Byte counters clear.
  - `output_from_cut`, `cycle_count` and `proto_err` clear to 0.
- **IDLE:**
  - `hash_rst` = 1, `hash_valid` = 0.
  - Moves to ABSORB on the first cycle with `rst_cut` = 0.
- **ABSORB:**
  - `hash_rst` = 0, `hash_valid` = 1.
  - `hash_data` = `input_to_cut[8*m+7 : 8*m]`, where m is the message byte index.
  - `hash_last` = 1 when m = `DATA_WIDTH`/8 − 1.
  - A transfer occurs when `hash_valid` & `hash_ready`; m then increments.
  - The transfer of the last byte moves the FSM to SQUEEZE.
  - While stalled, `hash_data` and `hash_last` are held.
- **SQUEEZE:**
  - `hash_valid` = 0.
  - Each `hash_out_valid` writes `hash_out` into byte k of `output_from_cut`; k then increments.
  - A strobe with k = N/8 − 1 moves the FSM to DONE.
- **DONE:**
  - `end_cut` = 1, held until `rst_cut` or `rst`.
  - `output_from_cut` is frozen.
- **`proto_err`:** set when `hash_out_valid` = 1 in any state other than SQUEEZE. The stray byte is discarded.
- **`cycle_count`:** increments every cycle the FSM is in ABSORB or SQUEEZE, and saturates at 0xFFFF_FFFF. It is frozen in DONE.
- **Counter widths:** m is `$clog2(DATA_WIDTH/8)+1` bits; k is `$clog2(N/8)+1` bits. Neither wraps, because the state changes on the terminal value.
- **`input_to_cut` sampling:** sampled live during ABSORB. The controller holds it stable while `rst_cut` is low.

## Timing
- **Values during reset:** `hash_rst` = 1. All other outputs are 0: `hash_data`, `hash_valid`, `hash_last`, `end_cut`, `output_from_cut`, `cycle_count`, `proto_err`.
- **Start-up:**
  - `rst_cut` falls at edge T0.
  - ABSORB is entered at T1; `hash_valid` is high from T1.
  - With `hash_ready` tied high, message byte m is presented at T1+m.
- **SQUEEZE:** entered on the edge that accepts the last byte. `hash_out_valid` is honoured from the first SQUEEZE cycle.
- **Completion:** the last digest byte is written on the same edge that enters DONE. `end_cut` and the complete `output_from_cut` are therefore valid together, one cycle after the final `hash_out_valid`.
- **Outputs:** `hash_rst`, `hash_valid`, `hash_last`, `hash_data` and `end_cut` are decoded from state and counters. None has a combinational path from `hash_ready` or `hash_out_valid`.
- **Abort:** `rst_cut` rising in any state aborts at the next edge. Any partial digest is discarded.

## Test plan
All scenarios use `DATA_WIDTH` = 32 and N = 88.
1. **Reset:** hold `rst` high for 3 cycles with random inputs → `hash_rst` = 1, all other outputs 0.
2. **Nominal run:**
   - Stimulus: `input_to_cut` = 0x44332211, `hash_ready` = 1, drop `rst_cut`; the model returns 0xA0..0xAA on consecutive cycles from the first SQUEEZE cycle.
   - Required: `hash_data` = 11, 22, 33, 44 with `hash_last` on 44.
   - Required: `output_from_cut` = 0xAAA9A8A7A6A5A4A3A2A1A0 and `end_cut` = 1.
   - Required: `cycle_count` = 15, and it holds.
3. **Backpressure:** `hash_ready` alternates 0/1 → each byte is held stable until accepted; the byte order is unchanged; `cycle_count` = 4 + 4 + 11 = 19 under the same squeeze model.
4. **Abort mid-squeeze:**
   - Stimulus: assert `rst_cut` after 5 digest bytes.
   - Required: next cycle IDLE, `output_from_cut` = 0, `end_cut` = 0, `cycle_count` = 0.
   - Required: a following full run matches scenario 2.
5. **Spurious strobe:**
   - Stimulus: pulse `hash_out_valid` with 0x5A during ABSORB.
   - Required: `proto_err` = 1, the digest is unaffected, and the run completes normally.
   - Required: `rst_cut` clears `proto_err`.
6. **DONE hold:** after completion, pulse `hash_out_valid` 3 times with `rst_cut` low → `end_cut` stays 1, `output_from_cut` is unchanged, `proto_err` = 1.

Source files
------------

// File: rtl/cut_spongent_adapter.sv
// Bridges the autotest controller's parallel CUT port to a byte-streaming Spongent core:
// absorbs the message LSB-first, collects the digest byte-wise and counts hash cycles.
module cut_spongent_adapter #(
    parameter int DATA_WIDTH = 32,
    parameter int N          = 88
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rst_cut,
    input  logic [DATA_WIDTH-1:0] input_to_cut,
    output logic [N-1:0]          output_from_cut,
    output logic                  end_cut,
    output logic                  hash_rst,
    output logic [7:0]            hash_data,
    output logic                  hash_valid,
    output logic                  hash_last,
    input  logic                  hash_ready,
    input  logic [7:0]            hash_out,
    input  logic                  hash_out_valid,
    output logic [31:0]           cycle_count,
    output logic                  proto_err
);

    localparam int MSG_BYTES = DATA_WIDTH / 8;
    localparam int DIG_BYTES = N / 8;
    localparam int MW        = $clog2(MSG_BYTES) + 1;
    localparam int KW        = $clog2(DIG_BYTES) + 1;
    localparam logic [MW-1:0] M_LAST = MW'(MSG_BYTES - 1);
    localparam logic [KW-1:0] K_LAST = KW'(DIG_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ABSORB  = 2'd1,
        SQUEEZE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t          state_reg;
    logic [MW-1:0]   m_reg;
    logic [KW-1:0]   k_reg;
    logic [31:0]     cycle_count_reg;
    logic            proto_err_reg;
    logic [7:0]      msg_byte [MSG_BYTES];
    logic [7:0]      dig_reg  [DIG_BYTES];

    // Message lanes are read live; the controller keeps input_to_cut stable during a run.
    generate
        for (genvar gi = 0; gi < MSG_BYTES; gi++) begin : g_msg
            assign msg_byte[gi] = input_to_cut[8*gi +: 8];
        end
    endgenerate

    // One register per digest lane, written only when its own index is current.
    generate
        for (genvar gi = 0; gi < DIG_BYTES; gi++) begin : g_dig
            always_ff @(posedge clk) begin
                if (rst || rst_cut) begin
                    dig_reg[gi] <= 8'h00;
                end else if (state_reg == SQUEEZE && hash_out_valid && k_reg == KW'(gi)) begin
                    dig_reg[gi] <= hash_out;
                end
            end
            assign output_from_cut[8*gi +: 8] = dig_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst || rst_cut) begin
            state_reg       <= IDLE;
            m_reg           <= '0;
            k_reg           <= '0;
            cycle_count_reg <= '0;
            proto_err_reg   <= 1'b0;
        end else begin
            // A digest strobe is only meaningful while squeezing; anything else is discarded.
            if (hash_out_valid && state_reg != SQUEEZE) begin
                proto_err_reg <= 1'b1;
            end
            if ((state_reg == ABSORB || state_reg == SQUEEZE) && cycle_count_reg != 32'hFFFF_FFFF) begin
                cycle_count_reg <= cycle_count_reg + 32'd1;
            end
            case (state_reg)
                IDLE: begin
                    state_reg <= ABSORB;
                    m_reg     <= '0;
                    k_reg     <= '0;
                end
                ABSORB: begin
                    if (hash_ready) begin
                        m_reg <= m_reg + MW'(1);
                        if (m_reg == M_LAST) begin
                            state_reg <= SQUEEZE;
                        end
                    end
                end
                SQUEEZE: begin
                    if (hash_out_valid) begin
                        k_reg <= k_reg + KW'(1);
                        if (k_reg == K_LAST) begin
                            state_reg <= DONE;
                        end
                    end
                end
                DONE: begin
                    state_reg <= DONE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Core-facing outputs depend only on registered state, never on the handshake inputs.
    always_comb begin
        hash_data = 8'h00;
        for (int i = 0; i < MSG_BYTES; i++) begin
            if (state_reg == ABSORB && m_reg == MW'(i)) begin
                hash_data = msg_byte[i];
            end
        end
    end

    assign hash_rst    = (state_reg == IDLE);
    assign hash_valid  = (state_reg == ABSORB);
    assign hash_last   = (state_reg == ABSORB) && (m_reg == M_LAST);
    assign end_cut     = (state_reg == DONE);
    assign cycle_count = cycle_count_reg;
    assign proto_err   = proto_err_reg;

endmodule
